// File: rtl/mem_arbiter.sv
// Arbitrates NUM_CH requesters onto one memory port (round-robin or fixed priority, with bus lock).
// Latency: grant -> mem_execute same cycle as req_ready; rsp_valid >= 3 cycles after req_ready.
// Backpressure: no grant while mem_ready=0 in IDLE; one command outstanding at a time.
module mem_arbiter #(
    parameter int NUM_CH = 5,
    parameter int ADDR_W = 10,
    parameter int DATA_W = 64,
    parameter int MODE   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          req_valid,
    input  logic [NUM_CH-1:0]          req_lock,
    input  logic [2*NUM_CH-1:0]        req_func,
    input  logic [ADDR_W*NUM_CH-1:0]   req_addr1,
    input  logic [ADDR_W*NUM_CH-1:0]   req_addr2,
    input  logic [DATA_W*NUM_CH-1:0]   req_wdata,
    output logic [NUM_CH-1:0]          req_ready,
    output logic [NUM_CH-1:0]          rsp_valid,
    output logic [2:0]                 owner,
    output logic                       mem_execute,
    output logic [1:0]                 mem_func,
    output logic [ADDR_W-1:0]          mem_address1,
    output logic [ADDR_W-1:0]          mem_address2,
    output logic [DATA_W-1:0]          mem_write_data,
    input  logic                       mem_ready
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, DONE} state_t;

    typedef struct packed {
        logic [1:0]        func;
        logic [ADDR_W-1:0] addr1;
        logic [ADDR_W-1:0] addr2;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    state_t            state_q;
    logic [IDX_W-1:0]  rr_q;
    logic [IDX_W-1:0]  owner_q;
    logic              locked_q;
    logic              busy_first_q;
    logic [NUM_CH-1:0] req_ready_q;
    logic [NUM_CH-1:0] rsp_valid_q;
    logic              mem_execute_q;
    cmd_t              cmd_q;

    logic [NUM_CH-1:0] elig;
    logic              gnt_vld;
    logic [IDX_W-1:0]  gnt_idx;
    logic [IDX_W-1:0]  rr_d;
    cmd_t              gnt_cmd;

    // A held lock narrows eligibility to the current owner only.
    always_comb begin
        elig = req_valid;
        if (locked_q && req_lock[owner_q]) begin
            elig = req_valid & (NUM_CH'(1) << owner_q);
        end
    end

    always_comb begin
        int c;
        c       = 0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            c = (MODE == 1) ? k : int'(rr_q) + k;
            if (c >= NUM_CH) begin
                c = c - NUM_CH;
            end
            if (!gnt_vld && elig[IDX_W'(c)]) begin
                gnt_vld = 1'b1;
                gnt_idx = IDX_W'(c);
            end
        end
    end

    always_comb begin
        gnt_cmd = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (gnt_idx == IDX_W'(k)) begin
                gnt_cmd.func  = req_func[2*k +: 2];
                gnt_cmd.addr1 = req_addr1[ADDR_W*k +: ADDR_W];
                gnt_cmd.addr2 = req_addr2[ADDR_W*k +: ADDR_W];
                gnt_cmd.wdata = req_wdata[DATA_W*k +: DATA_W];
            end
        end
    end

    assign rr_d = (gnt_idx == IDX_W'(NUM_CH - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            rr_q          <= '0;
            owner_q       <= '0;
            locked_q      <= 1'b0;
            busy_first_q  <= 1'b0;
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            mem_execute_q <= 1'b0;
            cmd_q         <= '0;
        end else begin
            req_ready_q   <= '0;
            rsp_valid_q   <= '0;
            mem_execute_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (locked_q && !req_lock[owner_q]) begin
                        locked_q <= 1'b0;
                    end
                    if (mem_ready && gnt_vld) begin
                        req_ready_q   <= NUM_CH'(1) << gnt_idx;
                        owner_q       <= gnt_idx;
                        cmd_q         <= gnt_cmd;
                        mem_execute_q <= 1'b1;
                        if (MODE == 0) begin
                            rr_q <= rr_d;
                        end
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    busy_first_q <= 1'b1;
                    state_q      <= BUSY;
                end
                BUSY: begin
                    // The memory may not have dropped mem_ready yet in the first busy cycle.
                    busy_first_q <= 1'b0;
                    if (!busy_first_q && mem_ready) begin
                        rsp_valid_q[owner_q] <= 1'b1;
                        state_q              <= DONE;
                    end
                end
                DONE: begin
                    locked_q    <= req_lock[owner_q];
                    cmd_q.func  <= '0;
                    cmd_q.wdata <= '0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready      = req_ready_q;
    assign rsp_valid      = rsp_valid_q;
    assign owner          = 3'(owner_q);
    assign mem_execute    = mem_execute_q;
    assign mem_func       = cmd_q.func;
    assign mem_address1   = cmd_q.addr1;
    assign mem_address2   = cmd_q.addr2;
    assign mem_write_data = cmd_q.wdata;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter NUM_CH, default 5: number of requesting channels (2..8).
REQ-002 Parameter ADDR_W, default 10: memory address width.
REQ-003 Parameter DATA_W, default 64: memory data width.
REQ-004 Parameter MODE, default 0: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high. Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req_valid  in  NUM_CH  per-channel request
- req_lock  in  NUM_CH  per-channel bus hold after completion
- req_func  in  2*NUM_CH  memory function, channel i at [2i+1:2i]
- req_addr1, req_addr2  in  ADDR_W*NUM_CH  addresses, packed the same way
- req_wdata  in  DATA_W*NUM_CH  write data, packed the same way
- req_ready  out  NUM_CH  one-cycle accept pulse
- rsp_valid  out  NUM_CH  one-cycle completion pulse
- owner  out  3  index of the current or last granted channel
- mem_execute  out  1  memory start strobe
- mem_func  out  2  memory function
- mem_address1, mem_address2  out  ADDR_W  memory addresses
- mem_write_data  out  DATA_W  memory write data
- mem_ready  in  1  memory idle/ready

Function
REQ-006 State machine SHALL have states IDLE, ISSUE, BUSY, DONE.
REQ-007 IDLE: when mem_ready=1 and any eligible req_valid=1, select the winner, capture its func/addr1/addr2/wdata into registers, pulse req_ready[winner] for that cycle, set owner, go to ISSUE.
REQ-008 Eligibility: all channels, except when the lock is held (REQ-013). In that case only owner is eligible.
REQ-009 MODE 0: search SHALL start at rr_ptr and wrap modulo NUM_CH. After each grant, rr_ptr = (winner+1) mod NUM_CH.
REQ-010 MODE 1: lowest-index valid channel wins. rr_ptr is unused.
REQ-011 ISSUE: drive mem_execute=1 for exactly one cycle with the captured command, then go to BUSY. The mem_* command outputs SHALL hold their captured values from ISSUE through DONE.
REQ-012 BUSY: ignore mem_ready in the first BUSY cycle. Afterwards, on mem_ready=1, pulse rsp_valid[owner] for one cycle and go to DONE.
REQ-013 DONE: if req_lock[owner]=1, set locked=1; otherwise clear it. Go to IDLE. Latency from req_ready to rsp_valid is at least 3 cycles.
REQ-014 locked SHALL clear in IDLE whenever req_lock[owner]=0.
REQ-015 Requesters SHALL hold req_valid and payload stable until req_ready. Payload changes after req_ready SHALL not affect the command in flight.
REQ-016 Simultaneous valid requests: exactly one req_ready bit SHALL be high per cycle. At most one command SHALL be outstanding.
REQ-017 If a request arrives while mem_ready=0 in IDLE, the block SHALL not grant it until mem_ready=1.
REQ-018 Outside ISSUE, mem_execute=0. In IDLE, mem_func and mem_write_data SHALL be 0; addresses SHALL hold their last value.
REQ-019 owner SHALL be a valid index < NUM_CH at all times.

Reset
REQ-020 While rst=1, regardless of clk:
- state = IDLE
- rr_ptr = 0, owner = 0, locked = 0
- all outputs = 0
REQ-021 rst asserted mid-transaction SHALL abort it with no rsp_valid pulse. After release, arbitration SHALL restart from rr_ptr = 0.

Verification
REQ-022 Single channel: MODE 0, ch2 requests func=1, addr1=0x005, mem_ready falls 1 cycle after execute and returns 2 cycles later -> req_ready[2] pulse, mem_execute one cycle with addr 0x005, rsp_valid[2] one cycle, owner=2.
REQ-023 Round-robin fairness: MODE 0, channels 0, 1, 4 continuously valid -> grant order 0,1,4,0,1,4, never two req_ready bits high at once.
REQ-024 Fixed priority: MODE 1, channels 1 and 3 continuously valid -> channel 1 granted every time; channel 3 granted only after req_valid[1] drops.
REQ-025 Lock: ch0 holds req_lock=1 across two transactions while ch3 is valid -> ch3 not granted until ch0 drops req_lock; ch3 is granted in the next IDLE with mem_ready=1.
REQ-026 Reset mid-BUSY: assert rst during BUSY for ch1 -> outputs zero immediately, no rsp_valid[1]. After release with ch1 and ch2 valid, ch1 is granted first (rr_ptr=0 search).
REQ-027 Memory not ready: req_valid[0]=1 with mem_ready=0 for 5 cycles -> no req_ready and no mem_execute until mem_ready=1, then grant the next cycle.
